// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

   typedef enum logic [1:0] {
      RESET_WAIT = 2'd0,
      FETCH      = 2'd1,
      FULL       = 2'd2,
      DISCARD    = 2'd3
   } fetch_state_t;

   localparam logic [31:0] IF_NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] IF_DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus: READ/BUSYWAIT handshake between fetch unit and memory.
interface instruction_fetch_unit_if;

   logic        IMEM_READ;
   logic [31:0] IMEM_ADDRESS;
   logic [31:0] IMEM_READDATA;
   logic        IMEM_BUSYWAIT;

   modport master (output IMEM_READ, output IMEM_ADDRESS,
                   input  IMEM_READDATA, input IMEM_BUSYWAIT);
   modport slave  (input  IMEM_READ, input IMEM_ADDRESS,
                   output IMEM_READDATA, output IMEM_BUSYWAIT);

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register; flush wins over push, push over pop.
module fetch_skid_buffer (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        i_push,
   input  logic        i_pop,
   input  logic        i_flush,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   output logic        o_full,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr
);

   logic        r_full;
   logic [31:0] r_pc;
   logic [31:0] r_instr;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_full  <= 1'b0;
         r_pc    <= '0;
         r_instr <= '0;
      end else if (i_flush) begin
         r_full <= 1'b0;
      end else if (i_push) begin
         r_full  <= 1'b1;
         r_pc    <= i_pc;
         r_instr <= i_instr;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end

   assign o_full  = r_full;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch requester: issues word reads, presents {PC, PC+4, instr, valid} to IF/ID.
//   state      | meaning
//   RESET_WAIT | first cycle after reset, no request yet
//   FETCH      | request outstanding, output slot may be free or held
//   FULL       | output and skid buffer both occupied, no request
//   DISCARD    | redirected while busy; waiting to drop the stale response
module instruction_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = IF_DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     STALL,
   input  logic                     BRANCH_TAKEN,
   input  logic [31:0]              BRANCH_TARGET,
   instruction_fetch_unit_if.master imem,
   output logic [31:0]              IF_PC,
   output logic [31:0]              IF_PC_PLUS4,
   output logic [31:0]              IF_INSTRUCTION,
   output logic                     IF_VALID
);

   fetch_state_t r_state;
   logic         r_imem_read;
   logic [31:0]  r_imem_addr;
   logic [31:0]  r_fetch_pc;
   logic [31:0]  r_target;
   logic         r_if_valid;
   logic [31:0]  r_if_pc;
   logic [31:0]  r_if_pc_plus4;
   logic [31:0]  r_if_instr;

   logic         w_complete;
   logic         w_consume;
   logic [31:0]  w_target;
   logic [31:0]  w_next_addr;
   logic         w_skid_push;
   logic         w_skid_pop;
   logic         w_skid_full;
   logic [31:0]  w_skid_pc;
   logic [31:0]  w_skid_instr;

   always_comb begin
      w_complete  = r_imem_read && !imem.IMEM_BUSYWAIT;
      w_consume   = r_if_valid && !STALL;
      w_target    = BRANCH_TARGET & ~32'h0000_0003;
      w_next_addr = r_imem_addr + 32'd4;
      w_skid_push = !BRANCH_TAKEN && (r_state == FETCH) && w_complete && r_if_valid && STALL;
      w_skid_pop  = !BRANCH_TAKEN && (r_state == FULL) && w_consume;
   end

   fetch_skid_buffer u_skid (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_push  (w_skid_push),
      .i_pop   (w_skid_pop),
      .i_flush (BRANCH_TAKEN),
      .i_pc    (r_imem_addr),
      .i_instr (imem.IMEM_READDATA),
      .o_full  (w_skid_full),
      .o_pc    (w_skid_pc),
      .o_instr (w_skid_instr)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state       <= RESET_WAIT;
         r_imem_read   <= 1'b0;
         r_imem_addr   <= RESET_PC;
         r_fetch_pc    <= RESET_PC;
         r_target      <= RESET_PC;
         r_if_valid    <= 1'b0;
         r_if_pc       <= '0;
         r_if_pc_plus4 <= '0;
         r_if_instr    <= NOP_INSTR;
      end else if (BRANCH_TAKEN) begin
         r_if_valid <= 1'b0;
         r_if_instr <= NOP_INSTR;
         r_fetch_pc <= w_target;
         if (!r_imem_read || w_complete) begin
            r_imem_addr <= w_target;
            r_imem_read <= 1'b1;
            r_state     <= FETCH;
         end else begin
            r_target <= w_target;
            r_state  <= DISCARD;
         end
      end else begin
         case (r_state)
            RESET_WAIT: begin
               r_imem_read <= 1'b1;
               r_imem_addr <= r_fetch_pc;
               r_state     <= FETCH;
            end
            FETCH: begin
               if (w_complete && (!r_if_valid || !STALL)) begin
                  r_if_valid    <= 1'b1;
                  r_if_pc       <= r_imem_addr;
                  r_if_pc_plus4 <= w_next_addr;
                  r_if_instr    <= imem.IMEM_READDATA;
                  r_imem_addr   <= w_next_addr;
                  r_fetch_pc    <= w_next_addr;
               end else if (w_complete) begin
                  // output held by STALL: response parked in the skid buffer
                  r_imem_read <= 1'b0;
                  r_fetch_pc  <= w_next_addr;
                  r_state     <= FULL;
               end else if (w_consume) begin
                  r_if_valid <= 1'b0;
                  r_if_instr <= NOP_INSTR;
               end
            end
            FULL: begin
               if (w_consume && w_skid_full) begin
                  r_if_pc       <= w_skid_pc;
                  r_if_pc_plus4 <= w_skid_pc + 32'd4;
                  r_if_instr    <= w_skid_instr;
                  r_imem_read   <= 1'b1;
                  r_imem_addr   <= r_fetch_pc;
                  r_state       <= FETCH;
               end
            end
            DISCARD: begin
               if (w_complete) begin
                  r_imem_addr <= r_target;
                  r_fetch_pc  <= r_target;
                  r_state     <= FETCH;
               end
            end
            default: r_state <= RESET_WAIT;
         endcase
      end
   end

   assign imem.IMEM_READ    = r_imem_read;
   assign imem.IMEM_ADDRESS = r_imem_addr;
   assign IF_VALID          = r_if_valid;
   assign IF_PC             = r_if_pc;
   assign IF_PC_PLUS4       = r_if_pc_plus4;
   assign IF_INSTRUCTION    = r_if_instr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a configurable-wait memory model.
module tb_instruction_fetch_unit;
   import if_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        STALL = 1'b0;
   logic        BRANCH_TAKEN = 1'b0;
   logic [31:0] BRANCH_TARGET = '0;
   logic [31:0] IF_PC, IF_PC_PLUS4, IF_INSTRUCTION;
   logic        IF_VALID;

   int n_cmp = 0;
   int n_bad = 0;
   int wait_cfg = 0;
   int wait_cnt = 0;

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .STALL          (STALL),
      .BRANCH_TAKEN   (BRANCH_TAKEN),
      .BRANCH_TARGET  (BRANCH_TARGET),
      .imem           (bus.master),
      .IF_PC          (IF_PC),
      .IF_PC_PLUS4    (IF_PC_PLUS4),
      .IF_INSTRUCTION (IF_INSTRUCTION),
      .IF_VALID       (IF_VALID)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   mem_word = 32'h0010_0293;
         32'h4:   mem_word = 32'h0030_7313;
         32'h8:   mem_word = 32'h0062_F3B3;
         default: mem_word = 32'hC000_0000 ^ a;
      endcase
   endfunction

   assign bus.IMEM_READDATA = mem_word(bus.IMEM_ADDRESS);
   assign bus.IMEM_BUSYWAIT = bus.IMEM_READ && (wait_cnt < wait_cfg);

   always @(posedge CLK) begin
      if (bus.IMEM_READ && bus.IMEM_BUSYWAIT) wait_cnt <= wait_cnt + 1;
      else                                    wait_cnt <= 0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   // holds reset for two cycles; release happens at a negedge so the next posedge is edge 1
   task automatic do_reset(input int wcfg);
      RESET = 1'b1;
      STALL = 1'b0;
      BRANCH_TAKEN = 1'b0;
      wait_cfg = wcfg;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   initial begin
      // reset values
      do_reset(0);
      RESET = 1'b1;
      #1;
      chk("rst_read",  32'(bus.IMEM_READ), 32'd0);
      chk("rst_addr",  bus.IMEM_ADDRESS, 32'h0);
      chk("rst_valid", 32'(IF_VALID), 32'd0);
      chk("rst_pc",    IF_PC, 32'h0);
      chk("rst_pc4",   IF_PC_PLUS4, 32'h0);
      chk("rst_instr", IF_INSTRUCTION, 32'h0000_0013);

      // zero-wait stream 0,4,8
      do_reset(0);
      tick();
      chk("z_e1_read",  32'(bus.IMEM_READ), 32'd1);
      chk("z_e1_addr",  bus.IMEM_ADDRESS, 32'h0);
      chk("z_e1_valid", 32'(IF_VALID), 32'd0);
      tick();
      chk("z_e2_valid", 32'(IF_VALID), 32'd1);
      chk("z_e2_pc",    IF_PC, 32'h0);
      chk("z_e2_pc4",   IF_PC_PLUS4, 32'h4);
      chk("z_e2_instr", IF_INSTRUCTION, 32'h0010_0293);
      tick();
      chk("z_e3_pc",    IF_PC, 32'h4);
      chk("z_e3_pc4",   IF_PC_PLUS4, 32'h8);
      chk("z_e3_instr", IF_INSTRUCTION, 32'h0030_7313);
      tick();
      chk("z_e4_pc",    IF_PC, 32'h8);
      chk("z_e4_pc4",   IF_PC_PLUS4, 32'hC);
      chk("z_e4_instr", IF_INSTRUCTION, 32'h0062_F3B3);

      // three wait cycles per read: address stable, one valid every 4 edges
      do_reset(3);
      for (int k = 1; k <= 13; k++) begin
         tick();
         chk($sformatf("w_addr_e%0d", k), bus.IMEM_ADDRESS, 32'(((k - 1) / 4) * 4));
         chk($sformatf("w_valid_e%0d", k), 32'(IF_VALID), 32'((k >= 5) && (k % 4 == 1)));
         if ((k >= 5) && (k % 4 == 1))
            chk($sformatf("w_pc_e%0d", k), IF_PC, 32'(((k - 5) / 4) * 4));
      end

      // stall while IF_PC=4: PC 8 parks in the skid buffer, then 8,12,16 stream out
      do_reset(0);
      tick(); tick(); tick();
      chk("s_pc_pre", IF_PC, 32'h4);
      STALL = 1'b1;
      for (int k = 4; k <= 7; k++) begin
         tick();
         chk($sformatf("s_hold_pc_e%0d", k), IF_PC, 32'h4);
         chk($sformatf("s_hold_v_e%0d", k),  32'(IF_VALID), 32'd1);
         chk($sformatf("s_read_e%0d", k),    32'(bus.IMEM_READ), 32'd0);
         chk($sformatf("s_skid_e%0d", k),    dut.u_skid.r_pc, 32'h8);
      end
      STALL = 1'b0;
      tick();
      chk("s_pc8",    IF_PC, 32'h8);
      chk("s_ins8",   IF_INSTRUCTION, 32'h0062_F3B3);
      chk("s_addr12", bus.IMEM_ADDRESS, 32'hC);
      tick();
      chk("s_pc12", IF_PC, 32'hC);
      chk("s_v12",  32'(IF_VALID), 32'd1);
      tick();
      chk("s_pc16", IF_PC, 32'h10);

      // redirect to 0x40 with zero wait; in-flight PC 8 is dropped
      do_reset(0);
      tick(); tick(); tick();
      BRANCH_TARGET = 32'h40;
      BRANCH_TAKEN = 1'b1;
      tick();
      BRANCH_TAKEN = 1'b0;
      chk("b_valid", 32'(IF_VALID), 32'd0);
      chk("b_instr", IF_INSTRUCTION, 32'h0000_0013);
      chk("b_addr",  bus.IMEM_ADDRESS, 32'h40);
      tick();
      chk("b_v40",  32'(IF_VALID), 32'd1);
      chk("b_pc40", IF_PC, 32'h40);
      chk("b_in40", IF_INSTRUCTION, 32'hC000_0040);
      tick();
      chk("b_pc44", IF_PC, 32'h44);

      // redirect to the top word: PC wraps to 0
      BRANCH_TARGET = 32'hFFFF_FFFC;
      BRANCH_TAKEN = 1'b1;
      tick();
      BRANCH_TAKEN = 1'b0;
      tick();
      chk("wrap_pc",  IF_PC, 32'hFFFF_FFFC);
      chk("wrap_pc4", IF_PC_PLUS4, 32'h0);
      tick();
      chk("wrap_pc0",  IF_PC, 32'h0);
      chk("wrap_ins0", IF_INSTRUCTION, 32'h0010_0293);

      // redirect to 0x103 while busy: DISCARD, then fetch 0x100
      do_reset(3);
      tick(); tick();
      BRANCH_TARGET = 32'h103;
      BRANCH_TAKEN = 1'b1;
      tick();
      BRANCH_TAKEN = 1'b0;
      chk("d_state3", 32'(dut.r_state), 32'(DISCARD));
      chk("d_addr3",  bus.IMEM_ADDRESS, 32'h0);
      chk("d_read3",  32'(bus.IMEM_READ), 32'd1);
      tick();
      chk("d_state4", 32'(dut.r_state), 32'(DISCARD));
      chk("d_addr4",  bus.IMEM_ADDRESS, 32'h0);
      tick();
      chk("d_addr5",  bus.IMEM_ADDRESS, 32'h100);
      chk("d_valid5", 32'(IF_VALID), 32'd0);
      chk("d_state5", 32'(dut.r_state), 32'(FETCH));
      tick(); tick(); tick();
      chk("d_valid8", 32'(IF_VALID), 32'd0);
      tick();
      chk("d_valid9", 32'(IF_VALID), 32'd1);
      chk("d_pc9",    IF_PC, 32'h100);
      chk("d_ins9",   IF_INSTRUCTION, 32'hC000_0100);

      // reset mid-wait with a held valid output
      do_reset(3);
      repeat (5) tick();
      chk("r_v_pre", 32'(IF_VALID), 32'd1);
      STALL = 1'b1;
      tick();
      RESET = 1'b1;
      #1;
      chk("r_read",  32'(bus.IMEM_READ), 32'd0);
      chk("r_valid", 32'(IF_VALID), 32'd0);
      chk("r_instr", IF_INSTRUCTION, 32'h0000_0013);
      do_reset(0);
      tick();
      chk("r_addr0", bus.IMEM_ADDRESS, 32'h0);
      chk("r_read1", 32'(bus.IMEM_READ), 32'd1);
      tick();
      chk("r_pc0",   IF_PC, 32'h0);
      chk("r_v0",    32'(IF_VALID), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Requester side of the instruction-memory interface. It holds the fetch PC, issues word reads to instruction_memory using a READ/BUSYWAIT handshake, and presents {PC, PC+4, instruction, valid} to the IF/ID pipeline register. It honours STALL from the hazard unit and redirects on taken branches and jumps from EX. A one-entry skid buffer lets the unit sustain one fetch per cycle with registered request outputs.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, ADDI x0,x0,0; value driven on IF_INSTRUCTION when not valid

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
STALL  in  1  hazard unit: IF/ID must hold its current contents
BRANCH_TAKEN  in  1  EX redirect request (branch taken, JAL, JALR)
BRANCH_TARGET  in  32  redirect address; bits [1:0] are ignored and forced to 0
IMEM_READ  out  1  read request; registered
IMEM_ADDRESS  out  32  word-aligned fetch address; registered; stable while IMEM_READ=1
IMEM_READDATA  in  32  instruction word from memory
IMEM_BUSYWAIT  in  1  memory still working; response not ready
IF_PC  out  32  PC of the presented instruction
IF_PC_PLUS4  out  32  IF_PC + 4 (mod 2^32)
IF_INSTRUCTION  out  32  presented instruction; NOP_INSTR when IF_VALID=0
IF_VALID  out  1  presented instruction is real

Behaviour:
- Reset (asynchronous): state=RESET_WAIT, IMEM_READ=0, IMEM_ADDRESS=RESET_PC, fetch PC=RESET_PC, IF_VALID=0, IF_PC=0, IF_PC_PLUS4=0, IF_INSTRUCTION=NOP_INSTR, skid buffer empty.
- Reset mid-transaction: IMEM_READ drops at once and the response is lost. The memory must tolerate an abandoned request.
- Handshake: a request completes on a rising edge with IMEM_READ=1 and IMEM_BUSYWAIT=0. IMEM_READDATA is sampled at that edge. IMEM_ADDRESS must not change while a request is pending.
- Consume event: IF_VALID=1 and STALL=0 at an edge.
- States:
  - RESET_WAIT: on the first edge after reset release -> FETCH; IMEM_READ=1, IMEM_ADDRESS=RESET_PC.
  - FETCH: request is outstanding.
    - On completion with the output slot free, or being consumed this edge: load the output regs, fetch PC+=4, keep IMEM_READ=1.
    - On completion with the output held: write the skid buffer, drop IMEM_READ -> FULL.
  - FULL: output and buffer both occupied; IMEM_READ=0. On a consume event the buffer moves to the output, IMEM_READ=1 at the next address -> FETCH.
  - DISCARD: redirect arrived while a request was pending with BUSYWAIT=1. Keep IMEM_READ/IMEM_ADDRESS until completion, drop the returned data, then issue IMEM_ADDRESS=target -> FETCH.
- Redirect (BRANCH_TAKEN=1) has priority over STALL and over any completion at the same edge:
  - clear IF_VALID (IF_INSTRUCTION=NOP_INSTR) and the skid buffer; fetch PC=target.
  - If no request is pending, or a completion occurs at this same edge (data dropped): IMEM_ADDRESS=target, IMEM_READ=1 -> FETCH.
  - Otherwise -> DISCARD, with the target held in a register. A second redirect during DISCARD overwrites the held target.
- Latency: with a zero-wait memory, the first IF_VALID appears one edge after the first request. Throughput is one instruction per cycle and the redirect penalty is one cycle. Each BUSYWAIT cycle adds one cycle.
- Ordering: instructions appear in program order with no duplicates or drops. Fetch PC wraps from 32'hFFFF_FFFC to 0.
- No combinational path from STALL or BRANCH_TAKEN to IMEM_READ or IMEM_ADDRESS.

Decomposition:
- Package if_pkg: fetch state enum (RESET_WAIT, FETCH, FULL, DISCARD), NOP_INSTR constant, default RESET_PC.
- Sub-module fetch_skid_buffer: one-entry {pc, instr} register with push, pop, full and flush.

Test Plan:
- Zero-wait memory holding ADDI x5,x0,1 at 0, ANDI x6,x0,3 at 4, AND x7,x5,x6 at 8, no stall -> IF_PC 0,4,8 on consecutive cycles. The first IF_VALID occurs two edges after reset release, and IF_PC_PLUS4 is 4,8,12.
- BUSYWAIT high for 3 cycles on each read -> IMEM_ADDRESS stays constant throughout every wait, with one valid instruction every 4 cycles, in order.
- STALL high for 4 cycles while IF_PC=4 -> outputs hold 4, the buffer captures PC 8, and IMEM_READ=0. After release, 8 then 12 follow with no gap or duplicate.
- BRANCH_TAKEN with target 0x40 while idle-pending in FETCH with zero wait -> the next IF_VALID is PC 0x40. The instruction at the old PC+4 never appears.
- BRANCH_TAKEN with target 0x103 during a BUSYWAIT period -> state goes to DISCARD, the old response is dropped, and the next address is 0x100.
- RESET asserted mid-wait -> IMEM_READ=0 and IF_VALID=0 immediately. After release, fetching restarts at RESET_PC.
